// File: rtl/agnus_audio_dma_scheduler_pkg.sv
// Shared constants and types for the Agnus audio DMA scheduler.
// Register addresses are word addresses [8:1]; channel n sits at base + 8*n.
package agnus_audio_dma_scheduler_pkg;

   localparam logic [7:0] AUDLCH_BASE = 8'h50;
   localparam logic [7:0] AUDLCL_BASE = 8'h51;
   localparam logic [7:0] AUDDAT_BASE = 8'h55;
   localparam logic [7:0] REG_IDLE    = 8'hFF;
   localparam int         AUD_STRIDE  = 8;

   // Chip-RAM word address, bit 0 corresponds to byte-address bit 1.
   typedef logic [19:0] chip_addr_t;

endpackage

// File: rtl/agnus_audio_ptr.sv
// One audio channel's location/pointer registers plus its per-line
// pending and restart (special) flags.
module agnus_audio_ptr
   import agnus_audio_dma_scheduler_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_clk7_en,
   input  logic        i_cck,
   input  logic        i_strhor,
   input  logic        i_en,
   input  logic        i_req,
   input  logic        i_dmas,
   input  logic        i_grant,
   input  logic        i_wr_lch,
   input  logic        i_wr_lcl,
   input  logic [15:0] i_data,
   output chip_addr_t  o_used_addr,
   output logic        o_pending
);

   chip_addr_t r_loc;
   chip_addr_t r_ptr;
   logic       r_pending;
   logic       r_special;

   // A restart fetch reads from the location register, otherwise from the running pointer.
   assign o_used_addr = r_special ? r_loc : r_ptr;
   assign o_pending   = r_pending;

   always_ff @(posedge i_clk) begin
      if (i_clk7_en) begin
         if (!i_reset_n) begin
            r_loc     <= '0;
            r_ptr     <= '0;
            r_pending <= 1'b0;
            r_special <= 1'b0;
         end else begin
            if (i_wr_lch) r_loc[19:15] <= i_data[4:0];
            if (i_wr_lcl) r_loc[14:0]  <= i_data[15:1];
            if (i_cck) begin
               if (i_strhor) begin
                  r_pending <= i_req & i_en;
                  r_special <= i_dmas & i_req & i_en;
               end else if (!i_en) begin
                  r_pending <= 1'b0;
                  r_special <= 1'b0;
               end else if (i_grant) begin
                  r_ptr     <= o_used_addr + 20'd1;
                  r_pending <= 1'b0;
                  r_special <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/agnus_audio_dma_scheduler.sv
// Audio DMA slot scheduler: four channels, each with a fixed slot at
// SLOT_BASE + 2*n; outputs are combinational so the fetch lands in the slot itself.
module agnus_audio_dma_scheduler
   import agnus_audio_dma_scheduler_pkg::*;
#(
   parameter logic [8:0] SLOT_BASE = 9'h00D,
   parameter int         NCH       = 4
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk7_en,
   input  logic        cck,
   input  logic [8:0]  hpos,
   input  logic        strhor,
   input  logic [3:0]  dmaen,
   input  logic [3:0]  audio_dmareq,
   input  logic [3:0]  audio_dmas,
   input  logic        aen,
   input  logic [7:0]  reg_address_in,
   input  logic [15:0] data_in,
   output logic        dma,
   output logic [19:0] address_out,
   output logic [7:0]  reg_address_out,
   output logic [1:0]  grant_ch
);

   logic [NCH-1:0] w_wr_lch;
   logic [NCH-1:0] w_wr_lcl;
   logic [NCH-1:0] w_slot;
   logic [NCH-1:0] w_pending;
   logic [NCH-1:0] w_grant;
   chip_addr_t     w_used [NCH];

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      assign w_wr_lch[n] = aen && (reg_address_in == AUDLCH_BASE + 8'(AUD_STRIDE * n));
      assign w_wr_lcl[n] = aen && (reg_address_in == AUDLCL_BASE + 8'(AUD_STRIDE * n));
      assign w_slot[n]   = (hpos == SLOT_BASE + 9'(2 * n));
      // The line strobe wins over a coincident slot: latching happens, no fetch.
      assign w_grant[n]  = w_slot[n] && w_pending[n] && dmaen[n] && !strhor;

      agnus_audio_ptr u_ptr (
         .i_clk       (clk),
         .i_reset_n   (reset_n),
         .i_clk7_en   (clk7_en),
         .i_cck       (cck),
         .i_strhor    (strhor),
         .i_en        (dmaen[n]),
         .i_req       (audio_dmareq[n]),
         .i_dmas      (audio_dmas[n]),
         .i_grant     (w_grant[n]),
         .i_wr_lch    (w_wr_lch[n]),
         .i_wr_lcl    (w_wr_lcl[n]),
         .i_data      (data_in),
         .o_used_addr (w_used[n]),
         .o_pending   (w_pending[n])
      );
   end

   // Slots never overlap, so at most one grant bit is set.
   always_comb begin
      dma             = 1'b0;
      grant_ch        = '0;
      address_out     = '0;
      reg_address_out = REG_IDLE;
      for (int n = 0; n < NCH; n++) begin
         if (w_grant[n]) begin
            dma             = 1'b1;
            grant_ch        = 2'(n);
            address_out     = w_used[n];
            reg_address_out = AUDDAT_BASE + 8'(AUD_STRIDE * n);
         end
      end
   end

endmodule

// File: tb/tb_agnus_audio_dma_scheduler.sv
// Scoreboard bench for the audio DMA scheduler: a per-colour-clock reference
// model pushes the expected bus-slot outcome, a monitor pops and compares.
module tb_agnus_audio_dma_scheduler;

   logic        clk;
   logic        reset_n;
   logic        clk7_en;
   logic        cck;
   logic [8:0]  hpos;
   logic        strhor;
   logic [3:0]  dmaen;
   logic [3:0]  audio_dmareq;
   logic [3:0]  audio_dmas;
   logic        aen;
   logic [7:0]  reg_address_in;
   logic [15:0] data_in;
   logic        dma;
   logic [19:0] address_out;
   logic [7:0]  reg_address_out;
   logic [1:0]  grant_ch;

   int n_tests = 0;
   int n_fail  = 0;

   // {dma, grant_ch, reg_address_out, address_out}
   logic [30:0] exp_q[$];

   // reference model state
   logic [19:0] m_loc [4];
   logic [19:0] m_ptr [4];
   logic [3:0]  m_pend;
   logic [3:0]  m_spec;

   // stimulus for the current colour clock
   logic [8:0]  g_hpos;
   logic        g_sh;
   logic        g_rst;
   logic [3:0]  g_en, g_req, g_dmas;
   logic        g_wr;
   logic [7:0]  g_wa;
   logic [15:0] g_wd;

   agnus_audio_dma_scheduler dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .clk7_en         (clk7_en),
      .cck             (cck),
      .hpos            (hpos),
      .strhor          (strhor),
      .dmaen           (dmaen),
      .audio_dmareq    (audio_dmareq),
      .audio_dmas      (audio_dmas),
      .aen             (aen),
      .reg_address_in  (reg_address_in),
      .data_in         (data_in),
      .dma             (dma),
      .address_out     (address_out),
      .reg_address_out (reg_address_out),
      .grant_ch        (grant_ch)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      reset_n = 1'b0; clk7_en = 1'b0; cck = 1'b0; hpos = '0; strhor = 1'b0;
      dmaen = '0; audio_dmareq = '0; audio_dmas = '0; aen = 1'b0;
      reg_address_in = '0; data_in = '0;
   end

   // Reference model: one step per colour clock, from the register-level rules.
   task automatic model_step();
      logic [30:0] e;
      logic [19:0] used;
      e = {1'b0, 2'd0, 8'hFF, 20'h0};
      if (g_rst) begin
         for (int n = 0; n < 4; n++) begin
            m_loc[n] = '0;
            m_ptr[n] = '0;
         end
         m_pend = '0;
         m_spec = '0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (!g_sh && g_hpos == 9'(13 + 2 * n) && m_pend[n] && g_en[n]) begin
               used = m_spec[n] ? m_loc[n] : m_ptr[n];
               e = {1'b1, 2'(n), 8'(8'h55 + 8 * n), used};
               m_ptr[n]  = used + 20'd1;
               m_pend[n] = 1'b0;
               m_spec[n] = 1'b0;
            end
         end
         if (g_sh) begin
            m_pend = g_req & g_en;
            m_spec = g_dmas & g_req & g_en;
         end else begin
            m_pend = m_pend & g_en;
            m_spec = m_spec & g_en;
         end
         if (g_wr) begin
            for (int n = 0; n < 4; n++) begin
               if (g_wa == 8'(8'h50 + 8 * n)) m_loc[n][19:15] = g_wd[4:0];
               if (g_wa == 8'(8'h51 + 8 * n)) m_loc[n][14:0]  = g_wd[15:1];
            end
         end
      end
      exp_q.push_back(e);
   endtask

   // Driver: one colour clock = four bus clocks, clk7_en on 0 and 2, cck on 2.
   // The register write strobe is only live in the cck cycle.
   task automatic tick();
      model_step();
      @(posedge clk); #1;
      reset_n = !g_rst; hpos = g_hpos; strhor = g_sh; dmaen = g_en;
      audio_dmareq = g_req; audio_dmas = g_dmas;
      reg_address_in = g_wa; data_in = g_wd;
      clk7_en = 1'b1; cck = 1'b0; aen = 1'b0;
      @(posedge clk); #1;
      clk7_en = 1'b0;
      @(posedge clk); #1;
      clk7_en = 1'b1; cck = 1'b1; aen = g_wr;
      @(posedge clk); #1;
      clk7_en = 1'b0; cck = 1'b0; aen = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] wa, input logic [15:0] wd);
      g_hpos = 9'h100; g_sh = 1'b0; g_rst = 1'b0; g_en = 4'hF;
      g_req = '0; g_dmas = '0; g_wr = 1'b1; g_wa = wa; g_wd = wd;
      tick();
      g_wr = 1'b0;
   endtask

   task automatic run_line(input logic [3:0] req, input logic [3:0] dmas,
                           input logic [3:0] en, input logic [8:0] sh_h,
                           input logic [3:0] dis_mask, input logic [8:0] dis_h,
                           input logic wr, input logic [8:0] wr_h,
                           input logic [7:0] wa, input logic [15:0] wd,
                           input logic [8:0] rst_h);
      for (int h = 0; h < 24; h++) begin
         g_hpos = 9'(h);
         g_sh   = (9'(h) == sh_h);
         g_rst  = (9'(h) == rst_h);
         g_en   = (9'(h) >= dis_h) ? (en & ~dis_mask) : en;
         g_req  = req;
         g_dmas = dmas;
         g_wr   = wr && (9'(h) == wr_h);
         g_wa   = wa;
         g_wd   = wd;
         tick();
      end
      g_wr = 1'b0;
   endtask

   task automatic simple_line(input logic [3:0] req, input logic [3:0] dmas);
      run_line(req, dmas, 4'hF, 9'h000, 4'h0, 9'h1FF, 1'b0, 9'h1FF, 8'h00, 16'h0, 9'h1FF);
   endtask

   // Scoreboard monitor: samples mid-cycle of each colour-clock update cycle.
   always @(negedge clk) begin
      if (clk7_en && cck) begin
         logic [30:0] e;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL no_expect hpos=%h got dma=%b addr=%h reg=%h", hpos, dma, address_out, reg_address_out);
         end else begin
            e = exp_q.pop_front();
            if (dma !== e[30] || reg_address_out !== e[27:20] || address_out !== e[19:0] ||
                (e[30] && grant_ch !== e[29:28])) begin
               n_fail++;
               $display("FAIL slot hpos=%h got dma=%b ch=%0d reg=%h addr=%h want dma=%b ch=%0d reg=%h addr=%h",
                        hpos, dma, grant_ch, reg_address_out, address_out,
                        e[30], e[29:28], e[27:20], e[19:0]);
            end
         end
      end
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL timeout after %0d tests", n_tests);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] wa;
      logic [8:0] sh_h, rst_h, dis_h, wr_h;
      for (int n = 0; n < 4; n++) begin
         m_loc[n] = '0;
         m_ptr[n] = '0;
      end
      m_pend = '0; m_spec = '0;
      g_wr = 1'b0; g_wa = '0; g_wd = '0;

      // reset with random inputs
      for (int i = 0; i < 4; i++) begin
         g_rst = 1'b1; g_hpos = 9'($urandom_range(0, 511)); g_sh = 1'($urandom);
         g_en = 4'($urandom); g_req = 4'($urandom); g_dmas = 4'($urandom);
         g_wr = 1'($urandom); g_wa = 8'($urandom); g_wd = 16'($urandom);
         tick();
      end
      g_wr = 1'b0;

      // normal fetch with restart, then continuation
      do_write(8'h50, 16'h0001);
      do_write(8'h51, 16'h2340);
      simple_line(4'b0001, 4'b0001);
      simple_line(4'b0001, 4'b0000);

      // all four channels, twice to show each pointer advanced by one
      simple_line(4'hF, 4'h0);
      simple_line(4'hF, 4'h0);

      // channel 2 disabled mid-line, then a line showing its pointer kept
      run_line(4'b0100, 4'h0, 4'hF, 9'h000, 4'b0100, 9'h005, 1'b0, 9'h1FF, 8'h00, 16'h0, 9'h1FF);
      simple_line(4'b0100, 4'h0);

      // coincident LCL3 write during a restart fetch
      do_write(8'h68, 16'h0000);
      do_write(8'h69, 16'h0100);
      run_line(4'b1000, 4'b1000, 4'hF, 9'h000, 4'h0, 9'h1FF, 1'b1, 9'h013, 8'h69, 16'h0200, 9'h1FF);
      simple_line(4'b1000, 4'b0000);
      simple_line(4'b1000, 4'b1000);

      // pointer wrap on channel 1
      do_write(8'h58, 16'h001F);
      do_write(8'h59, 16'hFFFE);
      simple_line(4'b0010, 4'b0010);
      simple_line(4'b0010, 4'b0000);

      // strobe landing on channel 0's slot, then mid-line reset
      run_line(4'b0001, 4'h0, 4'hF, 9'h00D, 4'h0, 9'h1FF, 1'b0, 9'h1FF, 8'h00, 16'h0, 9'h1FF);
      run_line(4'hF, 4'h0, 4'hF, 9'h000, 4'h0, 9'h1FF, 1'b0, 9'h1FF, 8'h00, 16'h0, 9'h00E);
      simple_line(4'hF, 4'h0);

      // randomized lines
      for (int i = 0; i < 30; i++) begin
         wa    = ($urandom_range(0, 3) != 0) ? 8'(8'h50 + 8 * $urandom_range(0, 3) + $urandom_range(0, 1))
                                             : 8'($urandom);
         sh_h  = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(12, 20)) : 9'h000;
         rst_h = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(1, 23)) : 9'h1FF;
         dis_h = 9'($urandom_range(1, 23));
         wr_h  = 9'($urandom_range(1, 23));
         run_line(4'($urandom), 4'($urandom), 4'($urandom_range(8, 15)) | 4'($urandom),
                  sh_h, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, dis_h,
                  1'($urandom), wr_h, wa, 16'($urandom), rst_h);
      end

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d leftover entries want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
